// File: rtl/lcd_nibble_reader.sv
// Read-side engine for the 4-bit character-LCD bus.
// Performs one HD44780-style read (upper nibble first) and assembles the byte.
// In busy-poll mode it re-reads the busy flag until BF=0 or the attempt limit is hit.
// The LCD pins belong to this block only while bus_busy=1.
module lcd_nibble_reader #(
    parameter int T_SETUP  = 2,
    parameter int T_EHIGH  = 12,
    parameter int T_HOLD   = 1,
    parameter int T_NIBGAP = 50,
    parameter int MAX_POLL = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       rs_sel,
    input  logic       poll,
    input  logic [3:0] lcd_d_in,
    output logic       ready,
    output logic       bus_busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] rd_data,
    output logic       done,
    output logic       timeout
);

    typedef enum logic [3:0] {
        IDLE,
        SETUP_H,
        EHI_H,
        HOLD_H,
        GAP,
        SETUP_L,
        EHI_L,
        HOLD_L,
        DONE,
        REPOLL
    } state_t;

    localparam logic [7:0] MAX_POLL_C = 8'(MAX_POLL);

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic [7:0] attempts;
    logic       rs_q;
    logic       poll_q;
    logic       timer_done;
    logic       repoll_go;
    logic       poll_exhausted;

    // Dwell counter reload value for each state (count runs reload..0).
    function automatic logic [7:0] dwell(input state_t s);
        case (s)
            SETUP_H, SETUP_L: dwell = 8'(T_SETUP - 1);
            EHI_H, EHI_L:     dwell = 8'(T_EHIGH - 1);
            HOLD_H, HOLD_L:   dwell = 8'(T_HOLD - 1);
            GAP, REPOLL:      dwell = 8'(T_NIBGAP - 1);
            default:          dwell = '0;
        endcase
    endfunction

    // Decisions taken on the DONE cycle; rd_data[7] is the busy flag just read.
    always_comb begin
        timer_done     = (cnt == '0);
        repoll_go      = poll_q && rd_data[7] && (attempts < MAX_POLL_C);
        poll_exhausted = poll_q && rd_data[7] && !(attempts < MAX_POLL_C);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic: each timed state leaves when its dwell counter reaches zero.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req)        state_nx = SETUP_H;
            SETUP_H: if (timer_done) state_nx = EHI_H;
            EHI_H:   if (timer_done) state_nx = HOLD_H;
            HOLD_H:  if (timer_done) state_nx = GAP;
            GAP:     if (timer_done) state_nx = SETUP_L;
            SETUP_L: if (timer_done) state_nx = EHI_L;
            EHI_L:   if (timer_done) state_nx = HOLD_L;
            HOLD_L:  if (timer_done) state_nx = DONE;
            DONE:    state_nx = repoll_go ? REPOLL : IDLE;
            REPOLL:  if (timer_done) state_nx = SETUP_H;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        ready    = 1'b0;
        bus_busy = 1'b1;
        lcd_e    = 1'b0;
        lcd_rs   = 1'b0;
        lcd_rw   = 1'b0;
        done     = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE: begin
                ready    = 1'b1;
                bus_busy = 1'b0;
            end
            SETUP_H, HOLD_H, GAP, SETUP_L, HOLD_L: begin
                lcd_rs = rs_q;
                lcd_rw = 1'b1;
            end
            EHI_H, EHI_L: begin
                lcd_e  = 1'b1;
                lcd_rs = rs_q;
                lcd_rw = 1'b1;
            end
            DONE: begin
                done    = !repoll_go;
                timeout = poll_exhausted;
            end
            default: ;
        endcase
    end

    // Dwell counter: reloaded whenever the state changes, otherwise counts down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_nx != state) begin
            cnt <= dwell(state_nx);
        end else if (cnt != '0) begin
            cnt <= cnt - 8'd1;
        end
    end

    // Request latching and poll attempt counting; poll is meaningless for data reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q     <= 1'b0;
            poll_q   <= 1'b0;
            attempts <= '0;
        end else if (state == IDLE && req) begin
            rs_q     <= rs_sel;
            poll_q   <= poll && !rs_sel;
            attempts <= 8'd1;
        end else if (state == DONE && repoll_go) begin
            attempts <= attempts + 8'd1;
        end
    end

    // Nibble capture on the last E-high cycle of each pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (state == EHI_H && timer_done) begin
            rd_data[7:4] <= lcd_d_in;
        end else if (state == EHI_L && timer_done) begin
            rd_data[3:0] <= lcd_d_in;
        end
    end

endmodule

// File: tb/tb_lcd_nibble_reader.sv
// Self-checking bench for lcd_nibble_reader: an LCD responder serves nibbles from a
// queue on each E pulse, and a transaction-level model predicts the outcome.
module tb_lcd_nibble_reader;

    localparam int T_SETUP  = 2;
    localparam int T_EHIGH  = 12;
    localparam int T_HOLD   = 1;
    localparam int T_NIBGAP = 50;
    localparam int READ_CYC = 2 * T_SETUP + 2 * T_EHIGH + 2 * T_HOLD + T_NIBGAP;
    localparam int PERIOD   = READ_CYC + 1 + T_NIBGAP;
    localparam int GAP_LOW  = T_HOLD + T_NIBGAP + T_SETUP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       req3 = 1'b0;
    logic       rs_sel = 1'b0;
    logic       poll = 1'b0;
    logic [3:0] lcd_d_in = 4'h0;

    logic       ready, bus_busy, lcd_e, lcd_rs, lcd_rw, done, timeout;
    logic [7:0] rd_data;
    logic       ready3, bus_busy3, lcd_e3, lcd_rs3, lcd_rw3, done3, timeout3;
    logic [7:0] rd_data3;

    logic       sel3 = 1'b0;
    logic       m_e, m_rs, m_rw, m_done, m_to, m_ready, m_busy;
    logic [7:0] m_rd;

    int checks = 0;
    int failures = 0;

    logic [3:0] nib_q[$];

    typedef struct {
        int         dones;
        int         done_cyc;
        int         pulses;
        int         ehi_min;
        int         ehi_max;
        int         gap1;
        int         rsrw_err;
        logic [7:0] data;
        bit         to_at_done;
        int         to_count;
        bit         idle_after;
    } obs_t;

    lcd_nibble_reader dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rs_sel(rs_sel), .poll(poll),
        .lcd_d_in(lcd_d_in), .ready(ready), .bus_busy(bus_busy), .lcd_e(lcd_e),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .rd_data(rd_data), .done(done),
        .timeout(timeout)
    );

    lcd_nibble_reader #(.MAX_POLL(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .rs_sel(rs_sel), .poll(poll),
        .lcd_d_in(lcd_d_in), .ready(ready3), .bus_busy(bus_busy3), .lcd_e(lcd_e3),
        .lcd_rs(lcd_rs3), .lcd_rw(lcd_rw3), .rd_data(rd_data3), .done(done3),
        .timeout(timeout3)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (sel3) begin
            m_e = lcd_e3; m_rs = lcd_rs3; m_rw = lcd_rw3; m_done = done3;
            m_to = timeout3; m_ready = ready3; m_busy = bus_busy3; m_rd = rd_data3;
        end else begin
            m_e = lcd_e; m_rs = lcd_rs; m_rw = lcd_rw; m_done = done;
            m_to = timeout; m_ready = ready; m_busy = bus_busy; m_rd = rd_data;
        end
    end

    // LCD responder: present the next queued nibble while E is high, garbage otherwise.
    always @(m_e) begin
        if (m_e && nib_q.size() > 0) lcd_d_in = nib_q.pop_front();
        else                         lcd_d_in = 4'($urandom);
    end

    task automatic load(input logic [7:0] b[$]);
        nib_q.delete();
        foreach (b[i]) begin
            nib_q.push_back(b[i][7:4]);
            nib_q.push_back(b[i][3:0]);
        end
    endtask

    // Transaction-level expectation: how many reads happen, what byte ends up, when done fires.
    function automatic void model(input bit rs, input bit pl, input logic [7:0] b[$],
                                  input int maxp, output int n, output logic [7:0] d,
                                  output bit to, output int dc);
        n = 1;
        if (pl && !rs) begin
            while (b[n-1][7] && n < maxp) n++;
        end
        d  = b[n-1];
        to = pl && !rs && d[7];
        dc = (n - 1) * PERIOD + READ_CYC;
    endfunction

    // Issue one request and observe the bus until a few cycles past done (bounded).
    task automatic run_txn(input bit use3, input bit rs, input bit pl, input bit hold,
                           input int budget, output obs_t o);
        int  elen;
        int  low_run;
        bit  prev_e;
        o = '{dones: 0, done_cyc: -1, pulses: 0, ehi_min: 1000, ehi_max: 0, gap1: -1,
              rsrw_err: 0, data: 8'h00, to_at_done: 1'b0, to_count: 0, idle_after: 1'b0};
        @(negedge clk);
        sel3 = use3; rs_sel = rs; poll = pl;
        if (use3) req3 = 1'b1; else req = 1'b1;
        @(posedge clk);
        prev_e = 1'b0; elen = 0; low_run = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (cyc == 0 && !hold) begin req = 1'b0; req3 = 1'b0; end
            if (m_e) begin
                if (!prev_e) begin
                    o.pulses++;
                    if (o.pulses == 2) o.gap1 = low_run;
                end
                elen++;
            end else begin
                if (prev_e) begin
                    if (elen < o.ehi_min) o.ehi_min = elen;
                    if (elen > o.ehi_max) o.ehi_max = elen;
                    elen = 0; low_run = 0;
                end
                low_run++;
            end
            if ((m_e || cyc < READ_CYC) && (m_rw !== 1'b1 || m_rs !== rs)) o.rsrw_err++;
            if (m_to) o.to_count++;
            if (m_done) begin
                o.dones++;
                if (o.dones == 1) begin
                    o.done_cyc = cyc; o.data = m_rd; o.to_at_done = m_to;
                end
                req = 1'b0; req3 = 1'b0;
            end
            prev_e = m_e;
            if (o.dones > 0 && cyc >= o.done_cyc + 4) break;
        end
        req = 1'b0; req3 = 1'b0;
        o.idle_after = m_ready && !m_busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (bus_busy !== 1'b0) begin failures++; $display("FAIL reset_bus_busy: got %b want 0", bus_busy); end
        checks++; if (lcd_e !== 1'b0) begin failures++; $display("FAIL reset_lcd_e: got %b want 0", lcd_e); end
        checks++; if ({lcd_rs, lcd_rw} !== 2'b00) begin failures++; $display("FAIL reset_rs_rw: got %b want 00", {lcd_rs, lcd_rw}); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        checks++; if ({done, timeout} !== 2'b00) begin failures++; $display("FAIL reset_done_to: got %b want 00", {done, timeout}); end
        checks++; if (ready3 !== 1'b1) begin failures++; $display("FAIL reset_ready3: got %b want 1", ready3); end
    endtask

    task automatic test_busy_read();
        obs_t o;
        load('{8'h83});
        run_txn(1'b0, 1'b0, 1'b0, 1'b0, READ_CYC + 20, o);
        checks++; if (o.done_cyc !== READ_CYC) begin failures++; $display("FAIL busy_latency: got %0d want %0d", o.done_cyc, READ_CYC); end
        checks++; if (o.data !== 8'h83) begin failures++; $display("FAIL busy_data: got %h want 83", o.data); end
        checks++; if (o.pulses !== 2) begin failures++; $display("FAIL busy_pulses: got %0d want 2", o.pulses); end
        checks++; if (o.ehi_min !== T_EHIGH || o.ehi_max !== T_EHIGH) begin failures++; $display("FAIL busy_ehigh: got %0d..%0d want %0d", o.ehi_min, o.ehi_max, T_EHIGH); end
        checks++; if (o.gap1 !== GAP_LOW) begin failures++; $display("FAIL busy_gap: got %0d want %0d", o.gap1, GAP_LOW); end
        checks++; if (o.rsrw_err !== 0) begin failures++; $display("FAIL busy_rs_rw: got %0d bad cycles want 0", o.rsrw_err); end
        checks++; if (o.dones !== 1 || o.to_count !== 0) begin failures++; $display("FAIL busy_pulses_done_to: got done=%0d to=%0d want 1/0", o.dones, o.to_count); end
        checks++; if (!o.idle_after) begin failures++; $display("FAIL busy_idle_after: got 0 want 1"); end
    endtask

    task automatic test_data_read_req_held();
        obs_t o;
        load('{8'h41, 8'h77});
        run_txn(1'b0, 1'b1, 1'b1, 1'b1, READ_CYC + 20, o);
        checks++; if (o.data !== 8'h41) begin failures++; $display("FAIL data_read_byte: got %h want 41", o.data); end
        checks++; if (o.rsrw_err !== 0) begin failures++; $display("FAIL data_read_rs: got %0d bad cycles want 0", o.rsrw_err); end
        checks++; if (o.pulses !== 2 || o.dones !== 1) begin failures++; $display("FAIL data_read_single: got pulses=%0d done=%0d want 2/1", o.pulses, o.dones); end
        checks++; if (o.done_cyc !== READ_CYC) begin failures++; $display("FAIL data_read_latency: got %0d want %0d", o.done_cyc, READ_CYC); end
    endtask

    task automatic test_poll();
        obs_t o;
        load('{8'h80, 8'h80, 8'h80, 8'h05});
        run_txn(1'b0, 1'b0, 1'b1, 1'b0, 4 * PERIOD + 20, o);
        checks++; if (o.pulses !== 8) begin failures++; $display("FAIL poll_pulses: got %0d want 8", o.pulses); end
        checks++; if (o.dones !== 1) begin failures++; $display("FAIL poll_dones: got %0d want 1", o.dones); end
        checks++; if (o.data !== 8'h05) begin failures++; $display("FAIL poll_data: got %h want 05", o.data); end
        checks++; if (o.to_count !== 0) begin failures++; $display("FAIL poll_timeout: got %0d want 0", o.to_count); end
        checks++; if (o.done_cyc !== 3 * PERIOD + READ_CYC) begin failures++; $display("FAIL poll_latency: got %0d want %0d", o.done_cyc, 3 * PERIOD + READ_CYC); end
    endtask

    task automatic test_poll_timeout();
        obs_t o;
        load('{8'h8a, 8'h9b, 8'hfc, 8'h00, 8'h00});
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 3 * PERIOD + 20, o);
        checks++; if (o.pulses !== 6) begin failures++; $display("FAIL timeout_pulses: got %0d want 6", o.pulses); end
        checks++; if (o.dones !== 1 || !o.to_at_done || o.to_count !== 1) begin failures++; $display("FAIL timeout_coincident: got done=%0d to_at_done=%0d to=%0d want 1/1/1", o.dones, o.to_at_done, o.to_count); end
        checks++; if (o.data !== 8'hfc) begin failures++; $display("FAIL timeout_data: got %h want fc", o.data); end
        checks++; if (!o.idle_after) begin failures++; $display("FAIL timeout_idle_after: got 0 want 1"); end
        sel3 = 1'b0;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int   ndone;
        load('{8'ha5});
        @(negedge clk);
        sel3 = 1'b0; rs_sel = 1'b1; poll = 1'b0; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (70) @(negedge clk);
        checks++; if (lcd_e !== 1'b1) begin failures++; $display("FAIL midreset_pre_e: got %b want 1", lcd_e); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (lcd_e !== 1'b0 || bus_busy !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL midreset_async: got e=%b busy=%b ready=%b want 0/0/1", lcd_e, bus_busy, ready); end
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++; if (ndone !== 0 || rd_data !== 8'h00) begin failures++; $display("FAIL midreset_no_done: got done=%0d rd=%h want 0/00", ndone, rd_data); end
        load('{8'h27});
        run_txn(1'b0, 1'b0, 1'b0, 1'b0, READ_CYC + 20, o);
        checks++; if (o.data !== 8'h27 || o.done_cyc !== READ_CYC) begin failures++; $display("FAIL midreset_recover: got %h@%0d want 27@%0d", o.data, o.done_cyc, READ_CYC); end
    endtask

    task automatic test_random();
        obs_t       o;
        logic [7:0] b[$];
        bit         rs, pl, to;
        int         nbf, n, dc;
        logic [7:0] d;
        for (int it = 0; it < 8; it++) begin
            rs  = 1'($urandom);
            pl  = 1'($urandom);
            nbf = $urandom_range(0, 3);
            b.delete();
            for (int k = 0; k < nbf; k++) b.push_back(8'($urandom) | 8'h80);
            b.push_back(8'($urandom) & 8'h7f);
            b.push_back(8'($urandom));
            model(rs, pl, b, 255, n, d, to, dc);
            load(b);
            run_txn(1'b0, rs, pl, 1'b0, dc + 20, o);
            checks++;
            if (o.dones !== 1 || o.done_cyc !== dc || o.data !== d || o.pulses !== 2 * n ||
                o.to_count !== int'(to) || o.rsrw_err !== 0 || !o.idle_after ||
                o.ehi_min !== T_EHIGH || o.ehi_max !== T_EHIGH) begin
                failures++;
                $display("FAIL random_%0d rs=%0d poll=%0d: got done=%0d@%0d data=%h pulses=%0d to=%0d rsrw=%0d idle=%0d eh=%0d..%0d want 1@%0d data=%h pulses=%0d to=%0d rsrw=0 idle=1 eh=%0d",
                         it, rs, pl, o.dones, o.done_cyc, o.data, o.pulses, o.to_count, o.rsrw_err,
                         o.idle_after, o.ehi_min, o.ehi_max, dc, d, 2 * n, to, T_EHIGH);
            end
        end
    endtask

    initial begin
        test_reset();
        test_busy_read();
        test_data_read_req_held();
        test_poll();
        test_poll_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_nibble_reader.md
Name: lcd_nibble_reader

Overview:
- Read-side engine for the 4-bit character-LCD bus (SF_D[11:8], LCD_E, LCD_RS, LCD_RW).
- Performs one HD44780-style read transaction: two nibble reads, upper nibble first, assembled into a byte.
- Reads either the busy flag plus address counter (RS=0) or DDRAM/CGRAM data (RS=1).
- Optional busy-poll mode re-reads until BF=0, with a timeout.
- Sits beside the LCD write engine. Owns the LCD pins only while `bus_busy`=1.

Parameters:
- T_SETUP, 2: cycles RS/RW stable before E rises (tAS ≥ 40 ns at 50 MHz).
- T_EHIGH, 12: cycles E held high per nibble (≥ 230 ns).
- T_HOLD, 1: cycles after E falls before RS/RW may change.
- T_NIBGAP, 50: cycles E low between the two nibbles (≥ 1 µs).
- MAX_POLL, 255: maximum read attempts in poll mode before timeout.

Ports:
- clk, in, 1: 50 MHz system clock.
- rst_n, in, 1: asynchronous active-low reset.
- req, in, 1: start a read. Sampled only when ready=1.
- rs_sel, in, 1: 0 = busy-flag/address read, 1 = data read. Latched on accept.
- poll, in, 1: 1 = repeat the RS=0 read until BF=0. Latched on accept; ignored when rs_sel=1.
- lcd_d_in, in, 4: SF_D[11:8] input path.
- ready, out, 1: idle, can accept req.
- bus_busy, out, 1: reader owns the bus; the writer must tri-state SF_D and not drive E/RS/RW.
- lcd_e, out, 1: LCD enable.
- lcd_rs, out, 1: register select.
- lcd_rw, out, 1: 1 = read.
- rd_data, out, 8: assembled byte.
- done, out, 1: one-cycle pulse when rd_data is valid.
- timeout, out, 1: one-cycle pulse, coincident with done, when poll attempts are exhausted.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready=1.
  - bus_busy, lcd_e, lcd_rs, lcd_rw, done, timeout = 0.
  - rd_data=8'h00; counters cleared.
  - Reset mid-transaction aborts immediately: E drops that instant and no done is issued.
- States: IDLE, SETUP_H, EHI_H, HOLD_H, GAP, SETUP_L, EHI_L, HOLD_L, DONE, REPOLL.
- Accept: in IDLE, req=1 at a clock edge → latch rs_sel and poll; go to SETUP_H; ready=0 and bus_busy=1 from that edge.
  - req while ready=0 is ignored, not queued.
- Signal levels per state:
  - lcd_rw=1 and lcd_rs=latched rs in every state from SETUP_H through HOLD_L.
  - lcd_rs=0 and lcd_rw=0 in IDLE, GAP is excluded from this rule (RS/RW stay asserted in GAP).
  - lcd_e=1 only in EHI_H and EHI_L.
- Dwell times: SETUP_x = T_SETUP cycles, EHI_x = T_EHIGH, HOLD_x = T_HOLD, GAP = T_NIBGAP, DONE = 1 cycle.
  - One down-counter of 8 bits is reloaded on each state entry.
- Sampling:
  - rd_data[7:4] is captured from lcd_d_in on the edge leaving EHI_H, i.e. the last E-high cycle.
  - rd_data[3:0] is captured on the edge leaving EHI_L.
  - rd_data holds its value until the next capture.
- Latency: done=1 exactly 2·T_SETUP + 2·T_EHIGH + 2·T_HOLD + T_NIBGAP cycles after the accept edge (80 at defaults), for one cycle.
- DONE exit:
  - Normal exit goes to IDLE with ready=1 and bus_busy=0 on the following edge.
  - Poll mode (poll=1, rs=0) with rd_data[7]=1 and attempts < MAX_POLL: do not pulse done. Go to REPOLL for T_NIBGAP cycles (bus_busy stays 1, E low), then SETUP_H.
  - Attempt counter is 8 bits, set to 1 on accept and incremented on each REPOLL.
  - Poll completion: done pulses when BF=0.
  - Poll exhaustion: when attempts = MAX_POLL and BF still 1, done and timeout pulse together; rd_data = last read.
- rs_sel=1 with poll=1: poll is ignored and a single read is performed.
- lcd_d_in is sampled only at the two capture edges; X or changing values elsewhere have no effect.

Test Plan:
- Reset, then idle 10 cycles → ready=1, bus_busy=0, lcd_e=0, rd_data=8'h00.
- req, rs_sel=0, poll=0; lcd_d_in=4'h8 during E1 and 4'h3 during E2 → lcd_rw=1 and lcd_rs=0 throughout; E high for 12 cycles twice, separated by 50 low cycles plus hold/setup; done at accept+80; rd_data=8'h83.
- req, rs_sel=1; nibbles 4'h4 then 4'h1 → lcd_rs=1; rd_data=8'h41 (ASCII 'A'); one done pulse; req held high during the transaction starts no second read until ready returns.
- poll=1, rs_sel=0; bench returns BF=1 (4'h8/4'h0) on three reads, then 4'h0/4'h5 → exactly four E-pairs; a single done; rd_data=8'h05; timeout=0.
- poll=1 with MAX_POLL=3 and BF held at 1 → three E-pairs; done and timeout both high in the same cycle; then IDLE.
- rst_n low during EHI_L → lcd_e=0 and bus_busy=0 without waiting for clk; no done; a subsequent req completes normally.
